life_grid_engine: RTL and testbench
===================================

Name: life_grid_engine

Overview:
- Consumes the 64-bit pseudo-random pattern produced by the upstream LFSR stage.
- Treats that pattern as an 8x8 Conway's Game of Life board and advances it one generation per enabled tick.
- Reports board state, generation count, and termination flags to the display/score logic downstream.
- Cell (row r, col c) = bit r*8+c; row 0 occupies bits 7:0, col 0 is the LSB of each row.

Parameters:
- WRAP, 1, 1 = toroidal neighbourhood (edges wrap); 0 = cells outside the board are dead.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- seed_in  input  64  pattern from the LFSR (shift_seed).
- load  input  1  copy seed_in into the board, clear status.
- run  input  1  level; free-run generations on tick while high.
- step  input  1  single-generation request (pulse) while not running.
- tick  input  1  generation-rate enable pulse from the clock divider.
- grid  output  64  current board.
- gen_count  output  GEN_W  generations computed since the last load.
- stable  output  1  last computed generation equalled its predecessor.
- extinct  output  1  board is all zero after a computed generation.
- busy  output  1  high in RUN state.

Behaviour:
- Reset (async, any time, including mid-generation): grid=0, gen_count=0, stable=0, extinct=0, busy=0, state=IDLE.
- Next-generation function is combinational over the whole board.
  - Per cell, n = live-neighbour count (0..8) over 8 neighbours, using WRAP addressing.
  - Live cell survives iff n is 2 or 3; dead cell is born iff n is 3.
- An update commits on the rising edge; new grid is visible the following cycle (1-cycle latency from the qualifying edge).
- States:
  - IDLE: board held.
  - RUN: free-running.
  - DONE: board frozen after termination.
- Priority, every cycle: load > stop/start > generation.
- load (any state): grid<=seed_in, gen_count<=0, stable<=0, extinct<=0, next state=IDLE. A simultaneous tick/step is ignored that cycle.
- IDLE:
  - run=1 -> RUN; no update that cycle.
  - else step=1 -> compute one generation, stay IDLE. tick is not required for step.
  - step while run=1 is ignored.
- RUN (busy=1):
  - run=0 -> IDLE, no update that cycle.
  - else tick=1 -> compute one generation.
  - If the computed next == current grid: commit, set stable=1, go to DONE.
  - If the computed next == 0: commit, set extinct=1, go to DONE.
  - Both stable and extinct may set together (e.g. empty board ticked).
- DONE: grid, gen_count, and flags frozen; run, step, and tick are ignored; only load or reset leaves DONE.
- Every committed generation increments gen_count, including the terminating one. gen_count saturates at all-ones and never wraps.
- stable and extinct are sticky until load or reset. A step from IDLE may also set these flags but stays in IDLE.
- Oscillators (period >1) are never flagged; the engine runs until run deasserts.
- Undefined/illegal state encoding recovers to IDLE.

Test Plan:
- Reset mid-RUN with board=64'h0000_0000_0038_0000 -> grid=0, gen_count=0, busy=0, flags=0, asynchronously (before next edge).
- Blinker: load 64'h0000_0000_0038_0000, run=1, 2 ticks -> grid=64'h0000_0000_1010_1000 then 64'h0000_0000_0038_0000, gen_count=2, stable=0, busy=1.
- Block still life: load 64'h0000_0000_1818_0000, run=1, 1 tick -> grid unchanged, gen_count=1, stable=1, state DONE; further ticks leave gen_count=1.
- Lone cell: load 64'h0000_0000_0000_0001, step pulse -> grid=0, extinct=1, gen_count=1, state IDLE.
- Wrap check with glider at bits {1,10,16,17,18}: WRAP=1, 32 ticks -> glider returns to its start pattern, gen_count=32. WRAP=0 -> glider degrades to a 2x2 block at a corner and stable=1.
- Priority/saturation:
  - load and tick together in RUN -> grid=seed_in, gen_count=0, state IDLE.
  - GEN_W=4 with a blinker for 20 ticks -> gen_count holds at 15.

Source files
------------

// File: rtl/life_grid_engine.sv
// 8x8 Game of Life engine: loads a seed board, advances one generation per
// step/tick, and freezes once the board settles or dies out.
module life_grid_engine #(
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      seed_in,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  input  logic             tick,
  output logic [63:0]      grid,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable,
  output logic             extinct,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [63:0]      grid_q;
  logic [63:0]      grid_d;
  logic [GEN_W-1:0] gen_count_q;
  logic [GEN_W-1:0] gen_count_d;
  logic             stable_q;
  logic             extinct_q;
  logic             busy_q;
  logic             next_same;
  logic             next_empty;

  // Neighbour k maps to offset index 0..8 skipping the centre (4); row/col
  // offsets are idx/3-1 and idx%3-1.
  genvar gi, gk;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_cell
      localparam int ROW = gi / 8;
      localparam int COL = gi % 8;
      logic [7:0] nbr;
      logic [3:0] cnt;

      for (gk = 0; gk < 8; gk++) begin : g_nbr
        localparam int IDX = (gk < 4) ? gk : gk + 1;
        localparam int NR  = ROW + IDX / 3 - 1;
        localparam int NC  = COL + IDX % 3 - 1;
        if (WRAP != 0 || (NR >= 0 && NR < 8 && NC >= 0 && NC < 8)) begin : g_live
          localparam int WR = (NR + 8) % 8;
          localparam int WC = (NC + 8) % 8;
          assign nbr[gk] = grid_q[WR*8 + WC];
        end else begin : g_edge
          assign nbr[gk] = 1'b0;
        end
      end

      always_comb begin
        cnt = '0;
        for (int k = 0; k < 8; k++) begin
          cnt = cnt + {3'b000, nbr[k]};
        end
      end

      assign grid_d[gi] = (cnt == 4'd3) || (grid_q[gi] && (cnt == 4'd2));
    end
  endgenerate

  assign next_same   = (grid_d == grid_q);
  assign next_empty  = (grid_d == 64'd0);
  assign gen_count_d = (&gen_count_q) ? gen_count_q : gen_count_q + GEN_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grid_q      <= '0;
      gen_count_q <= '0;
      stable_q    <= 1'b0;
      extinct_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else if (load) begin
      state_q     <= ST_IDLE;
      grid_q      <= seed_in;
      gen_count_q <= '0;
      stable_q    <= 1'b0;
      extinct_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end else if (step) begin
            // A single step may raise the flags but never leaves IDLE.
            grid_q      <= grid_d;
            gen_count_q <= gen_count_d;
            if (next_same)  stable_q  <= 1'b1;
            if (next_empty) extinct_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (tick) begin
            grid_q      <= grid_d;
            gen_count_q <= gen_count_d;
            if (next_same)  stable_q  <= 1'b1;
            if (next_empty) extinct_q <= 1'b1;
            if (next_same || next_empty) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_count_q;
  assign stable    = stable_q;
  assign extinct   = extinct_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: three instances (toroidal, bounded, 4-bit
// counter) share stimulus and are checked against a behavioural board model.
module tb_life_grid_engine;

  localparam logic [63:0] BLINK  = 64'h0000_0000_0038_0000;
  localparam logic [63:0] BLINKV = 64'h0000_0000_1010_1000;
  localparam logic [63:0] BLOCK  = 64'h0000_0000_1818_0000;
  localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] seed_in;
  logic        load, run, step, tick;

  logic [63:0] grid_w, grid_f, grid_s;
  logic [15:0] gc_w, gc_f;
  logic [3:0]  gc_s;
  logic        st_w, st_f, st_s, ex_w, ex_f, ex_s, bz_w, bz_f, bz_s;

  logic [63:0] d_grid [3];
  logic [63:0] d_gen  [3];
  logic        d_st   [3];
  logic        d_ex   [3];
  logic        d_bz   [3];

  logic [63:0] m_grid [3];
  int          m_gen  [3];
  logic        m_st   [3];
  logic        m_ex   [3];
  int          m_mode [3];
  bit          m_wrap [3];
  int          m_gmax [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  life_grid_engine #(.WRAP(1), .GEN_W(16)) u_wrap (
    .clk(clk), .reset(reset), .seed_in(seed_in), .load(load), .run(run),
    .step(step), .tick(tick), .grid(grid_w), .gen_count(gc_w),
    .stable(st_w), .extinct(ex_w), .busy(bz_w));

  life_grid_engine #(.WRAP(0), .GEN_W(16)) u_flat (
    .clk(clk), .reset(reset), .seed_in(seed_in), .load(load), .run(run),
    .step(step), .tick(tick), .grid(grid_f), .gen_count(gc_f),
    .stable(st_f), .extinct(ex_f), .busy(bz_f));

  life_grid_engine #(.WRAP(1), .GEN_W(4)) u_small (
    .clk(clk), .reset(reset), .seed_in(seed_in), .load(load), .run(run),
    .step(step), .tick(tick), .grid(grid_s), .gen_count(gc_s),
    .stable(st_s), .extinct(ex_s), .busy(bz_s));

  assign d_grid[0] = grid_w;
  assign d_grid[1] = grid_f;
  assign d_grid[2] = grid_s;
  assign d_gen[0]  = {48'd0, gc_w};
  assign d_gen[1]  = {48'd0, gc_f};
  assign d_gen[2]  = {60'd0, gc_s};
  assign d_st[0] = st_w;  assign d_st[1] = st_f;  assign d_st[2] = st_s;
  assign d_ex[0] = ex_w;  assign d_ex[1] = ex_f;  assign d_ex[2] = ex_s;
  assign d_bz[0] = bz_w;  assign d_bz[1] = bz_f;  assign d_bz[2] = bz_s;

  // Conway rule evaluated cell by cell with explicit neighbour arithmetic.
  function automatic logic [63:0] life_next(input logic [63:0] b, input bit wrap);
    logic [63:0] nx;
    nx = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (dr != 0 || dc != 0) begin
              if (wrap) begin
                rr = (rr + 8) % 8;
                cc = (cc + 8) % 8;
                n = n + int'(b[rr*8 + cc]);
              end else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                n = n + int'(b[rr*8 + cc]);
              end
            end
          end
        end
        nx[r*8 + c] = (n == 3) || (b[r*8 + c] && n == 2);
      end
    end
    return nx;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_grid[i] = '0;
      m_gen[i]  = 0;
      m_st[i]   = 1'b0;
      m_ex[i]   = 1'b0;
      m_mode[i] = M_IDLE;
    end
  endtask

  task automatic model_commit(input int i);
    logic [63:0] nx;
    nx = life_next(m_grid[i], m_wrap[i]);
    if (nx == m_grid[i]) m_st[i] = 1'b1;
    if (nx == 64'd0)     m_ex[i] = 1'b1;
    if (m_mode[i] == M_RUN && (nx == m_grid[i] || nx == 64'd0)) m_mode[i] = M_DONE;
    m_grid[i] = nx;
    if (m_gen[i] < m_gmax[i]) m_gen[i] = m_gen[i] + 1;
  endtask

  task automatic model_edge(input logic ld, input logic rn, input logic sp,
                            input logic tk, input logic [63:0] sd);
    for (int i = 0; i < 3; i++) begin
      if (ld) begin
        m_grid[i] = sd;
        m_gen[i]  = 0;
        m_st[i]   = 1'b0;
        m_ex[i]   = 1'b0;
        m_mode[i] = M_IDLE;
      end else if (m_mode[i] == M_IDLE) begin
        if (rn) m_mode[i] = M_RUN;
        else if (sp) model_commit(i);
      end else if (m_mode[i] == M_RUN) begin
        if (!rn) m_mode[i] = M_IDLE;
        else if (tk) model_commit(i);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s/u%0d grid", tag, i), d_grid[i], m_grid[i]);
      chk($sformatf("%s/u%0d gen", tag, i), d_gen[i], 64'(m_gen[i]));
      chk($sformatf("%s/u%0d stable", tag, i), 64'(d_st[i]), 64'(m_st[i]));
      chk($sformatf("%s/u%0d extinct", tag, i), 64'(d_ex[i]), 64'(m_ex[i]));
      chk($sformatf("%s/u%0d busy", tag, i), 64'(d_bz[i]), 64'(m_mode[i] == M_RUN));
    end
  endtask

  task automatic apply(input logic ld, input logic rn, input logic sp,
                       input logic tk, input logic [63:0] sd, input string tag);
    load = ld; run = rn; step = sp; tick = tk; seed_in = sd;
    @(posedge clk);
    model_edge(ld, rn, sp, tk, sd);
    #1;
    check_all(tag);
    $display("[TB] %-10s ld=%0b run=%0b step=%0b tick=%0b grid=%h gen=%0d st=%0b ex=%0b busy=%0b",
             tag, ld, rn, sp, tk, grid_w, gc_w, st_w, ex_w, bz_w);
  endtask

  initial begin
    m_wrap[0] = 1'b1; m_wrap[1] = 1'b0; m_wrap[2] = 1'b1;
    m_gmax[0] = 65535; m_gmax[1] = 65535; m_gmax[2] = 15;
    reset = 1'b1; load = 1'b0; run = 1'b0; step = 1'b0; tick = 1'b0; seed_in = '0;
    model_reset();
    #2;
    check_all("reset");
    #10 reset = 1'b0;

    // Blinker oscillates and is never flagged.
    apply(1'b1, 1'b0, 1'b0, 1'b0, BLINK, "blk_load");
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0, "blk_start");
    apply(1'b0, 1'b1, 1'b0, 1'b1, '0, "blk_tick1");
    chk("blink_vertical", grid_w, BLINKV);
    apply(1'b0, 1'b1, 1'b0, 1'b1, '0, "blk_tick2");
    chk("blink_back", grid_w, BLINK);
    chk("blink_gen", 64'(gc_w), 64'd2);
    chk("blink_stable", 64'(st_w), 64'd0);
    chk("blink_busy", 64'(bz_w), 64'd1);

    // Asynchronous reset between clock edges while running.
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0, "blk_hold");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_grid", grid_w, 64'd0);
    chk("async_rst_busy", 64'(bz_w), 64'd0);
    #1 reset = 1'b0;

    // Block still life terminates after one tick and freezes.
    apply(1'b1, 1'b0, 1'b0, 1'b0, BLOCK, "blo_load");
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0, "blo_start");
    apply(1'b0, 1'b1, 1'b0, 1'b1, '0, "blo_tick");
    chk("block_grid", grid_w, BLOCK);
    chk("block_stable", 64'(st_w), 64'd1);
    chk("block_done", 64'(bz_w), 64'd0);
    for (int k = 0; k < 3; k++) apply(1'b0, 1'b1, 1'b1, 1'b1, '0, "blo_frozen");
    chk("block_gen_frozen", 64'(gc_w), 64'd1);

    // Lone cell dies on a single step and stays in IDLE.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 64'd1, "lone_load");
    apply(1'b0, 1'b0, 1'b1, 1'b0, '0, "lone_step");
    chk("lone_grid", grid_w, 64'd0);
    chk("lone_extinct", 64'(ex_w), 64'd1);
    chk("lone_gen", 64'(gc_w), 64'd1);
    chk("lone_busy", 64'(bz_w), 64'd0);

    // Glider: wraps home after 32 generations on the torus.
    apply(1'b1, 1'b0, 1'b0, 1'b0, GLIDER, "gli_load");
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0, "gli_start");
    for (int k = 0; k < 32; k++) apply(1'b0, 1'b1, 1'b0, 1'b1, '0, "gli_tick");
    chk("glider_home", grid_w, GLIDER);
    chk("glider_gen", 64'(gc_w), 64'd32);

    // Load wins over a simultaneous tick in RUN.
    apply(1'b1, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, "prio_load");
    chk("prio_grid", grid_w, 64'hDEAD_BEEF_0123_4567);
    chk("prio_gen", 64'(gc_w), 64'd0);
    chk("prio_busy", 64'(bz_w), 64'd0);

    // Generation counter saturation on the 4-bit instance.
    apply(1'b1, 1'b0, 1'b0, 1'b0, BLINK, "sat_load");
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0, "sat_start");
    for (int k = 0; k < 20; k++) apply(1'b0, 1'b1, 1'b0, 1'b1, '0, "sat_tick");
    chk("sat_gen_small", 64'(gc_s), 64'd15);
    chk("sat_gen_wide", 64'(gc_w), 64'd20);

    // Randomised traffic, with sparse seeds so boards die out now and then.
    for (int k = 0; k < 400; k++) begin
      logic        ld, rn, sp, tk;
      logic [63:0] sd;
      ld = ($urandom_range(0, 19) == 0);
      rn = ($urandom_range(0, 7) != 0);
      sp = ($urandom_range(0, 3) == 0);
      tk = $urandom_range(0, 1) == 1;
      sd = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) sd = sd & {$urandom, $urandom} & {$urandom, $urandom};
      apply(ld, rn, sp, tk, sd, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
